// File: rtl/trans_feeder.sv
// Transmit-side transaction source: packs 4x32-bit words into 128-bit transactions, queues them
// and presents them to the validator with a valid/ack handshake. Optional macro: TRANS_SEQ_EN.
module trans_feeder #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                word_i,
    input  logic                       word_valid_i,
    output logic                       word_ready_o,
    input  logic                       block_start_i,
    output logic [127:0]               data_o,
    output logic                       valid_o,
    input  logic                       ack_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ack_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [95:0]     asm_q, asm_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            pend_q, pend_d;
    logic [127:0]    data_q, data_d;
    logic            ack_err_q, ack_err_d;
    logic [127:0]    mem_q [DEPTH];

    logic            full, accept, push, pop;
    logic [8:0]      low_bits;
    logic [127:0]    push_data;

`ifdef TRANS_SEQ_EN
    logic [8:0]      seq_q, seq_d;
    assign low_bits = seq_q;
`else
    assign low_bits = word_i[8:0];
`endif

    assign full         = (level_q == LW'(DEPTH));
    assign word_ready_o = !((idx_q == 2'd3) && full);
    assign accept       = word_valid_i && word_ready_o;
    assign push         = accept && (idx_q == 2'd3);
    assign pop          = (state_q == PRESENT) && ack_i;
    // Upstream bit 9 is never trusted; the block flag comes from our own tracking.
    assign push_data    = {asm_q, word_i[31:10], pend_q | block_start_i, low_bits};

    assign data_o    = data_q;
    assign valid_o   = (state_q == PRESENT);
    assign level_o   = level_q;
    assign ack_err_o = ack_err_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pend_d    = pend_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
`ifdef TRANS_SEQ_EN
        seq_d     = seq_q;
`endif
        if (accept) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    asm_d[95:64] = word_i;
                2'd1:    asm_d[63:32] = word_i;
                2'd2:    asm_d[31:0]  = word_i;
                default: ;
            endcase
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            pend_d   = 1'b0;
`ifdef TRANS_SEQ_EN
            seq_d    = seq_q + 9'd1;
`endif
        end else if (block_start_i) begin
            pend_d = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: ;
        endcase
        case (state_q)
            IDLE: begin
                if (ack_i) ack_err_d = 1'b1;
                if (level_q != '0) begin
                    data_d  = mem_q[rd_ptr_q];
                    state_d = PRESENT;
                end
            end
            PRESENT: if (ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            asm_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pend_q    <= 1'b1;
            data_q    <= '0;
            ack_err_q <= 1'b0;
`ifdef TRANS_SEQ_EN
            seq_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
`ifdef TRANS_SEQ_EN
            seq_q     <= seq_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read once the level says they were written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: tb/tb_trans_feeder.sv
// Directed bench for trans_feeder: assembly, block flag, FIFO fill/order, push+pop, ack error, reset.
module tb_trans_feeder;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  word_i = '0;
    logic         word_valid_i = 1'b0;
    logic         word_ready_o;
    logic         block_start_i = 1'b0;
    logic [127:0] data_o;
    logic         valid_o;
    logic         ack_i = 1'b0;
    logic [3:0]   level_o;
    logic         ack_err_o;

    int nchk = 0;
    int nerr = 0;
    int seq = 0;
    logic [127:0] exp_q[$];

    trans_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(word_ready_o), .block_start_i(block_start_i), .data_o(data_o),
        .valid_o(valid_o), .ack_i(ack_i), .level_o(level_o), .ack_err_o(ack_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected transaction with hand-chosen block bit; low 9 bits depend on the build.
    function automatic logic [127:0] mk(input logic [31:0] w0, w1, w2, w3, input logic b9);
        logic [8:0] lo;
`ifdef TRANS_SEQ_EN
        lo = 9'(seq);
`else
        lo = w3[8:0];
`endif
        seq++;
        return {w0, w1, w2, w3[31:10], b9, lo};
    endfunction

    task automatic push_word(input logic [31:0] w, input logic bs);
        int n = 0;
        @(negedge clk);
        word_i = w; word_valid_i = 1'b1; block_start_i = bs;
        while (!word_ready_o && n < 50) begin @(negedge clk); n++; end
        if (!word_ready_o) check("word_timeout", 0, 1);
        @(posedge clk); #1;
        word_valid_i = 1'b0; block_start_i = 1'b0;
    endtask

    // bs_at: word index during which block_start_i pulses (4 = none)
    task automatic push_txn(input logic [31:0] w0, w1, w2, w3, input int bs_at, input logic b9);
        exp_q.push_back(mk(w0, w1, w2, w3, b9));
        push_word(w0, bs_at == 0);
        push_word(w1, bs_at == 1);
        push_word(w2, bs_at == 2);
        push_word(w3, bs_at == 3);
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!valid_o && n < 50) begin @(negedge clk); n++; end
        if (!valid_o) check("valid_timeout", 0, 1);
    endtask

    task automatic ack_one(input string tag);
        logic [127:0] e;
        wait_valid();
        if (exp_q.size() == 0) begin check({tag, "_noexp"}, 0, 1); e = '0; end
        else e = exp_q.pop_front();
        check(tag, data_o, e);
        ack_i = 1'b1;
        @(posedge clk); #1;
        ack_i = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ackerr", ack_err_o, 0);
        @(negedge clk); rst_n = 1'b1;
        check("rst_ready", word_ready_o, 1);

        // First transaction: bit 9 forced by pending-after-reset
        push_txn(32'hAAAA0000, 32'h0001BBBB, 32'h00000002, 32'h00000C00, 4, 1'b1);
        @(negedge clk);
        check("t1_level", level_o, 1);
        check("t1_valid_lat", valid_o, 0);
        @(negedge clk);
        check("t1_valid", valid_o, 1);
`ifndef TRANS_SEQ_EN
        check("t1_data_lit", data_o, 128'hAAAA0000_0001BBBB_00000002_00000E00);
`endif
        ack_one("t1_data");
        @(negedge clk);
        check("t1_valid_drop", valid_o, 0);
        check("t1_level_pop", level_o, 0);

        // Block flag: none, then pulsed during word 1
        push_txn(32'h1, 32'h2, 32'h3, 32'h00000200, 4, 1'b0);
        ack_one("t2_noblock");
        push_txn(32'h4, 32'h5, 32'h6, 32'h00000400, 1, 1'b1);
        ack_one("t3_block");

        // Fill FIFO with ack held low
        for (int k = 0; k < DEPTH; k++)
            push_txn(32'h10000000 + k, k, ~k, 32'(k) << 10, 4, 1'b0);
        @(negedge clk);
        check("fill_level", level_o, DEPTH);
        check("fill_valid", valid_o, 1);
        check("fill_head", data_o, exp_q[0]);
        push_word(32'h9000_0000, 1'b0);
        push_word(32'h9000_0001, 1'b0);
        push_word(32'h9000_0002, 1'b0);
        @(negedge clk);
        word_i = 32'h0000_2400; word_valid_i = 1'b1;
        check("full_ready_idx3", word_ready_o, 0);
        check("full_level", level_o, DEPTH);
        check("full_head_stable", data_o, exp_q.pop_front());
        ack_i = 1'b1;
        @(posedge clk); #1; ack_i = 1'b0;
        @(negedge clk);
        check("after_ack_ready", word_ready_o, 1);
        check("after_ack_level", level_o, DEPTH - 1);
        @(posedge clk); #1; word_valid_i = 1'b0;
        exp_q.push_back(mk(32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 32'h0000_2400, 1'b0));
        @(negedge clk);
        check("ninth_level", level_o, DEPTH);
        for (int k = 0; k < DEPTH; k++) ack_one("drain_order");
        @(negedge clk);
        check("drain_level", level_o, 0);

        // Push and pop on the same edge
        push_txn(32'hA1, 32'hA2, 32'hA3, 32'h00000800, 4, 1'b0);
        wait_valid();
        check("pp_headA", data_o, exp_q.pop_front());
        exp_q.push_back(mk(32'hB1, 32'hB2, 32'hB3, 32'h00000C00, 1'b0));
        push_word(32'hB1, 1'b0);
        push_word(32'hB2, 1'b0);
        push_word(32'hB3, 1'b0);
        @(negedge clk);
        word_i = 32'h00000C00; word_valid_i = 1'b1; ack_i = 1'b1;
        @(posedge clk); #1; word_valid_i = 1'b0; ack_i = 1'b0;
        @(negedge clk);
        check("pp_level", level_o, 1);
        check("pp_gap", valid_o, 0);
        @(negedge clk);
        check("pp_validB", valid_o, 1);
        ack_one("pp_dataB");

        // Ack while idle
        @(negedge clk);
        ack_i = 1'b1;
        @(posedge clk); #1; ack_i = 1'b0;
        @(negedge clk);
        check("ackerr_set", ack_err_o, 1);
        check("ackerr_level", level_o, 0);
        @(negedge clk);
        check("ackerr_sticky", ack_err_o, 1);

        // Reset with a presented transaction and a partial assembly
        push_txn(32'hC1, 32'hC2, 32'hC3, 32'h00001000, 4, 1'b0);
        wait_valid();
        push_word(32'hD0, 1'b0);
        push_word(32'hD1, 1'b0);
        @(negedge clk);
        check("prereset_valid", valid_o, 1);
        rst_n = 1'b0; #1;
        check("reset_valid", valid_o, 0);
        check("reset_level", level_o, 0);
        check("reset_ackerr", ack_err_o, 0);
        exp_q.delete(); seq = 0;
        @(negedge clk); rst_n = 1'b1;
        push_txn(32'hE0, 32'hE1, 32'hE2, 32'h00001400, 4, 1'b1);
        ack_one("postreset_e");
        push_txn(32'hF0, 32'hF1, 32'hF2, 32'h00001801, 4, 1'b0);
        ack_one("postreset_f");
        push_txn(32'hF4, 32'hF5, 32'hF6, 32'h00001C02, 4, 1'b0);
        ack_one("postreset_g");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
